// File: rtl/result_uart_pkg.sv
// Shared types and constants for the write-back result UART.
// A frame is a header/address byte followed by the data high and low bytes.
package result_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] FRAME_HDR       = 4'hA;
  localparam int         BYTES_PER_FRAME = 3;
  localparam int         ENTRY_W         = 20;

  // Byte idx of the frame carrying entry e = {addr, data}.
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] e, input logic [1:0] idx);
    case (idx)
      2'd0:    frame_byte = {FRAME_HDR, e[19:16]};
      2'd1:    frame_byte = e[15:8];
      default: frame_byte = e[7:0];
    endcase
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO, head visible combinationally; push when full and pop when
// empty are ignored, so the caller owns drop/overflow policy.
module result_fifo
  import result_uart_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wr_dat,
  output logic [WIDTH-1:0]       o_rd_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_dat  = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Captures register write-backs into a FIFO and sends each as a 3-byte 8N1 frame.
// First start bit one cycle after the capture edge; captures arriving while full are dropped (sticky overflow).
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [3:0]        capture_addr,
  input  logic [DATA_W-1:0] capture_data,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow
);
  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_FRAME - 1);

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit;
  logic [1:0]         r_byte;
  logic [7:0]         r_shift;
  logic [ENTRY_W-1:0] r_frame;
  logic               r_tx;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_baud_done;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;

  assign w_push      = capture_en && !w_full;
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wr_dat ({capture_addr, capture_data}),
    .o_rd_dat (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // tx is registered with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      r_frame    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (capture_en && w_full) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_frame <= w_head;
            r_shift <= frame_byte(w_head, 2'd0);
            r_baud  <= '0;
            r_byte  <= '0;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_byte < LAST_BYTE) begin
              r_byte  <= r_byte + 2'd1;
              r_shift <= frame_byte(r_frame, r_byte + 2'd1);
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_byte  <= '0;
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx        = r_tx;
  assign busy      = (r_state != IDLE) || (w_count != '0);
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: queue/timeline reference model checked every cycle,
// an independent UART receiver, and directed plus random capture traffic.
module tb_result_uart_tx;
  localparam int CPB       = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = 30 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic [3:0]  capture_addr = '0;
  logic [15:0] capture_data = '0;
  logic        tx, busy, fifo_full, overflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .DATA_W       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .capture_en   (capture_en),
    .capture_addr (capture_addr),
    .capture_data (capture_data),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of pending entries and a position within the frame being sent.
  logic [19:0] mq[$];
  bit          m_ovf = 1'b0;
  int          m_pos = -1;
  bit [29:0]   m_bits = '0;
  bit          m_valid = 1'b0;

  function automatic bit [29:0] frame_bits(input logic [19:0] e);
    bit [7:0]  b [3];
    bit [29:0] f;
    b[0] = {4'hA, e[19:16]};
    b[1] = e[15:8];
    b[2] = e[7:0];
    for (int k = 0; k < 3; k++) begin
      f[k*10] = 1'b0;
      for (int i = 0; i < 8; i++) f[k*10+1+i] = b[k][i];
      f[k*10+9] = 1'b1;
    end
    return f;
  endfunction

  initial forever begin
    bit was_full;
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_pos   = -1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      was_full = (mq.size() == DEPTH);
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FRAME_CYC) m_pos = -1;
      end else if (mq.size() > 0) begin
        m_bits = frame_bits(mq.pop_front());
        m_pos  = 0;
      end
      if (capture_en) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back({capture_addr, capture_data});
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk1("tx", tx, (m_pos < 0) ? 1'b1 : m_bits[m_pos / CPB]);
      chk1("busy", busy, (m_pos >= 0) || (mq.size() != 0));
      chk1("fifo_full", fifo_full, mq.size() == DEPTH);
      chk1("overflow", overflow, m_ovf);
    end
  end

  // Independent receiver: sample each bit mid-way.
  typedef struct {
    logic [7:0] b;
    int         st;
    bit         stop_ok;
  } rx_t;
  rx_t rx_q[$];
  bit  rx_busy = 1'b0;

  initial forever begin
    rx_t r;
    @(negedge clk);
    if (!reset && m_valid && tx === 1'b0) begin
      rx_busy = 1'b1;
      r.st = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        r.b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      r.stop_ok = (tx === 1'b1);
      rx_q.push_back(r);
      rx_busy = 1'b0;
    end
  end

  task automatic cap(input logic en, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    capture_en   = en;
    capture_addr = a;
    capture_data = d;
  endtask

  task automatic flush_rx();
    int w = 0;
    while (rx_busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    rx_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    capture_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    flush_rx();
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < 12000) begin
      @(negedge clk);
      w++;
    end
    chk1({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic get_byte(input string name, input logic [7:0] exp, output int st);
    int  w = 0;
    rx_t r;
    st = 0;
    while (rx_q.size() == 0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (rx_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no byte received, expected %0h", name, exp);
    end else begin
      r = rx_q.pop_front();
      chk(name, int'(r.b), int'(exp));
      chk1({name, "_stop"}, r.stop_ok, 1'b1);
      st = r.st;
    end
  endtask

  task automatic get_frame(input string name, input logic [3:0] a, input logic [15:0] d, output int st);
    int s1, s2;
    get_byte({name, "_b0"}, {4'hA, a}, st);
    get_byte({name, "_b1"}, d[15:8], s1);
    get_byte({name, "_b2"}, d[7:0], s2);
  endtask

  initial begin
    int s0, s1, s2, t1, lim;
    logic [7:0] b0;

    // 1: reset values, single capture timing and frame contents
    do_reset();
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_full", fifo_full, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    cap(1'b1, 4'd3, 16'h1234);
    cap(1'b0, 4'd0, 16'h0);
    chk1("t1_tx_at_capture", tx, 1'b1);
    @(negedge clk);
    chk1("t1_tx_low_next", tx, 1'b0);
    get_frame("t1", 4'd3, 16'h1234, s0);
    wait_idle("t1");
    t1 = cyc;
    chk("t1_frame_len", t1 - s0, 120);

    // 2: back-to-back captures, one idle cycle between frames
    cap(1'b1, 4'd1, 16'h00FF);
    cap(1'b1, 4'd2, 16'hFF00);
    cap(1'b0, 4'd0, 16'h0);
    get_frame("t2a", 4'd1, 16'h00FF, s1);
    get_frame("t2b", 4'd2, 16'hFF00, s2);
    chk("t2_frame_spacing", s2 - s1, 121);
    chk1("t2_ovf", overflow, 1'b0);
    wait_idle("t2");

    // 3: ten consecutive captures, the tenth is dropped
    for (int i = 0; i < 10; i++) begin
      cap(1'b1, 4'(i), 16'(i));
      if (i == 9) begin
        chk1("t3_full_before_drop", fifo_full, 1'b1);
        chk1("t3_ovf_before_drop", overflow, 1'b0);
      end
    end
    cap(1'b0, 4'd0, 16'h0);
    chk1("t3_ovf", overflow, 1'b1);
    chk1("t3_full", fifo_full, 1'b1);
    for (int i = 0; i < 9; i++) get_frame($sformatf("t3_f%0d", i), 4'(i), 16'(i), s0);
    wait_idle("t3");
    chk("t3_no_extra_bytes", rx_q.size(), 0);

    // 4: capture coincides with a pop while full
    do_reset();
    for (int i = 0; i < 9; i++) cap(1'b1, 4'(i), 16'h0100 + 16'(i));
    for (int j = 9; j < 122; j++) cap(1'b0, 4'd0, 16'h0);
    cap(1'b1, 4'hF, 16'hDEAD);
    chk1("t4_full_pre", fifo_full, 1'b1);
    chk1("t4_ovf_pre", overflow, 1'b0);
    cap(1'b0, 4'd0, 16'h0);
    chk1("t4_ovf", overflow, 1'b1);
    chk1("t4_full_after_pop", fifo_full, 1'b0);
    chk1("t4_next_start", tx, 1'b0);

    // 5: reset in the middle of byte 1
    repeat (55) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("t5_tx", tx, 1'b1);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_ovf", overflow, 1'b0);
    flush_rx();
    cap(1'b1, 4'd5, 16'hABCD);
    cap(1'b0, 4'd0, 16'h0);
    get_frame("t5", 4'd5, 16'hABCD, s0);
    wait_idle("t5");

    // 6: no enable, changing address/data
    for (int i = 0; i < 500; i++) cap(1'b0, 4'($urandom), 16'($urandom));
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_tx", tx, 1'b1);
    chk("t6_no_bytes", rx_q.size(), 0);

    // Random traffic: alternating sparse and heavy phases
    for (int ph = 0; ph < 6; ph++) begin
      lim = (ph % 2 == 1) ? 1 : 40;
      for (int i = 0; i < 500; i++)
        cap($urandom_range(0, lim) == 0, 4'($urandom), 16'($urandom));
    end
    cap(1'b0, 4'd0, 16'h0);
    wait_idle("rand");
    if (rx_q.size() > 0) begin
      b0 = rx_q[0].b;
      chk("rand_first_hdr", int'(b0[7:4]), 'hA);
    end
    flush_rx();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
